// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_CNT_W        = 4;

    // One memory access as seen on the DMEM bus; used for both requesters.
    typedef struct packed {
        logic                  we;
        logic                  re;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    // Same address/data, both enables cleared.
    function automatic mem_req_t req_quiet(mem_req_t r);
        mem_req_t q;
        q    = r;
        q.we = 1'b0;
        q.re = 1'b0;
        return q;
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive denied DMA cycles and flags the cycle that must
// schedule a forced core stall. The counter clears itself on that cycle.
module starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic denied,
    output logic stall_trig
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] starve_cnt;

    assign stall_trig = denied & (starve_cnt == LAST);

    // Any non-denied cycle or a trigger restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !denied || stall_trig) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: the core has fixed priority, the DMA port is
// served on idle core cycles or during a forced one-cycle core stall after
// STARVE_LIMIT consecutive denials.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_read_en,
    input  logic              core_write_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_we,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state, state_nxt;
    mem_req_t   core_req, dma_req, bus_req;
    logic       core_active;
    logic       grant;
    logic       denied;
    logic       stall_trig;

    assign core_active = core_read_en | core_write_en;
    assign core_rdata  = mem_rdata;
    assign core_stall  = (state == STALL);

    assign core_req = '{we: core_write_en, re: core_read_en,
                        addr: core_addr, wdata: core_wdata};
    assign dma_req  = '{we: dma_req_valid & dma_req_we,
                        re: dma_req_valid & ~dma_req_we,
                        addr: dma_req_addr, wdata: dma_req_wdata};

    assign mem_addr     = bus_req.addr;
    assign mem_wdata    = bus_req.wdata;
    assign mem_write_en = bus_req.we;
    assign mem_read_en  = bus_req.re;

    assign grant  = dma_req_valid & dma_req_ready;
    assign denied = dma_req_valid & ~dma_req_ready & (state == IDLE);

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .denied     (denied),
        .stall_trig (stall_trig)
    );

    // State register; reset drops any scheduled stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus mux, DMA grant and next state. During reset nothing is granted
    // and DMEM sees no enables, so an in-flight DMA access never lands.
    always_comb begin
        state_nxt     = state;
        dma_req_ready = 1'b0;
        bus_req       = req_quiet(core_req);
        case (state)
            IDLE: begin
                dma_req_ready = ~core_active;
                if (core_active) begin
                    bus_req = core_req;
                end else if (dma_req_valid) begin
                    bus_req = dma_req;
                end
                if (stall_trig) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                dma_req_ready = 1'b1;
                bus_req       = dma_req;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            dma_req_ready = 1'b0;
            bus_req       = req_quiet(bus_req);
        end
    end

    // Response one cycle behind the grant; read data captured at the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_rsp_valid <= 1'b0;
            dma_rsp_rdata <= '0;
        end else begin
            dma_rsp_valid <= grant;
            if (grant) begin
                dma_rsp_rdata <= dma_req_we ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cre = 1'b0, cwe = 1'b0;
    logic [31:0] ca = '0, cd = '0;
    logic        dv = 1'b0, dwe = 1'b0;
    logic [31:0] da = '0, dd = '0;

    logic [31:0] c_rdata, r_rdata, m_addr, m_wdata, m_rdata;
    logic        c_stall, d_ready, r_valid, m_we, m_re;

    logic [31:0] c_rdata1, r_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic        c_stall1, d_ready1, r_valid1, m_we1, m_re1;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] refmem [256];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .core_read_en(cre), .core_write_en(cwe), .core_addr(ca), .core_wdata(cd),
        .core_rdata(c_rdata), .core_stall(c_stall),
        .dma_req_valid(dv), .dma_req_ready(d_ready), .dma_req_we(dwe),
        .dma_req_addr(da), .dma_req_wdata(dd),
        .dma_rsp_valid(r_valid), .dma_rsp_rdata(r_rdata),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_write_en(m_we),
        .mem_read_en(m_re), .mem_rdata(m_rdata)
    );

    dmem_arbiter #(.STARVE_LIMIT(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .core_read_en(cre), .core_write_en(cwe), .core_addr(ca), .core_wdata(cd),
        .core_rdata(c_rdata1), .core_stall(c_stall1),
        .dma_req_valid(dv), .dma_req_ready(d_ready1), .dma_req_we(dwe),
        .dma_req_addr(da), .dma_req_wdata(dd),
        .dma_rsp_valid(r_valid1), .dma_rsp_rdata(r_rdata1),
        .mem_addr(m_addr1), .mem_wdata(m_wdata1), .mem_write_en(m_we1),
        .mem_read_en(m_re1), .mem_rdata(m_rdata1)
    );

    // Environment memories: combinational read, write at the clock edge.
    assign m_rdata  = mem0[m_addr[7:0]];
    assign m_rdata1 = mem1[m_addr1[7:0]];

    always @(posedge clk) begin
        if (m_we)  mem0[m_addr[7:0]]  <= m_wdata;
        if (m_we1) mem1[m_addr1[7:0]] <= m_wdata1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          md_stall = 1'b0;
    int          md_deny  = 0;
    bit          md_rv    = 1'b0;
    logic [31:0] md_rd    = '0;

    logic        e_ready, e_we, e_re;
    logic [31:0] e_addr, e_wd;

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (md_stall) begin
                e_ready = 1'b1;
                e_addr = da; e_wd = dd; e_we = dv & dwe; e_re = dv & ~dwe;
            end else if (cre | cwe) begin
                e_ready = 1'b0;
                e_addr = ca; e_wd = cd; e_we = cwe; e_re = cre;
            end else if (dv) begin
                e_ready = 1'b1;
                e_addr = da; e_wd = dd; e_we = dwe; e_re = ~dwe;
            end else begin
                e_ready = 1'b1;
                e_addr = ca; e_wd = cd; e_we = 1'b0; e_re = 1'b0;
            end
            if (rst) begin
                e_ready = 1'b0; e_we = 1'b0; e_re = 1'b0;
            end

            chk("dma_req_ready", d_ready, e_ready);
            chk("mem_write_en", m_we, e_we);
            chk("mem_read_en", m_re, e_re);
            chk("mem_addr", m_addr, e_addr);
            chk("mem_wdata", m_wdata, e_wd);
            chk("core_rdata", c_rdata, mem0[m_addr[7:0]]);
            chk("core_stall", c_stall, md_stall);
            chk("dma_rsp_valid", r_valid, md_rv);
            chk("dma_rsp_rdata", r_rdata, md_rd);

            if (rst) begin
                md_stall = 1'b0; md_deny = 0; md_rv = 1'b0; md_rd = '0;
            end else begin
                md_rv = dv & e_ready;
                if (dv & e_ready) md_rd = dwe ? 32'h0 : refmem[da[7:0]];
                if (e_we) refmem[e_addr[7:0]] = e_wd;
                if (!md_stall && dv && !e_ready) begin
                    md_deny++;
                    if (md_deny == LIMIT) begin
                        md_stall = 1'b1; md_deny = 0;
                    end
                end else begin
                    md_deny = 0; md_stall = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit re, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit v, input bit w,
                         input logic [31:0] qa, input logic [31:0] qd);
        @(posedge clk);
        #1;
        rst = r; cre = re; cwe = we; ca = a; cd = d;
        dv = v; dwe = w; da = qa; dd = qd;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    bit          pend;
    bit          nv, nw, nr, ncw;
    logic [31:0] na, nd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0; mem1[i] = '0; refmem[i] = '0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("reset core_stall", c_stall, 0);
        chk("reset rsp_valid", r_valid, 0);
        chk("reset rsp_rdata", r_rdata, 0);

        // DMA write then read back with the core idle
        drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
        chk("t1 ready wr", d_ready, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h40, 32'h0);
        chk("t1 ready rd", d_ready, 1);
        chk("t1 rsp1 valid", r_valid, 1);
        chk("t1 rsp1 data", r_rdata, 0);
        idle();
        chk("t1 rsp2 valid", r_valid, 1);
        chk("t1 rsp2 data", r_rdata, 32'hDEADBEEF);
        chk("t1 stall", c_stall, 0);
        idle();
        chk("t1 rsp gone", r_valid, 0);

        // Core loads every cycle, DMA read held: stall every 5th cycle
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 0, 32'h44, 0, 1, 0, 32'h40, 0);
            chk($sformatf("t2 ready c%0d", i), d_ready, (i % 5) == 0);
            chk($sformatf("t2 stall c%0d", i), c_stall, (i % 5) == 0);
            chk($sformatf("t2 rsp c%0d", i), r_valid, i == 6);
        end
        chk("t2 rsp data", r_rdata, 32'hDEADBEEF);
        idle();
        chk("t2 last rsp", r_valid, 1);
        idle();

        // Same-cycle core store and DMA write to one address
        drive(0, 0, 1, 32'h80, 32'h11, 1, 1, 32'h80, 32'h22);
        chk("t3 ready", d_ready, 0);
        chk("t3 wdata", m_wdata, 32'h11);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h22);
        chk("t3 ready2", d_ready, 1);
        chk("t3 core wrote", mem0[8'h80], 32'h11);
        idle();
        chk("t3 final mem", mem0[8'h80], 32'h22);
        chk("t3 rsp", r_valid, 1);

        // Reset asserted in the STALL cycle
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 32'h44, 0, 1, 1, 32'h90, 32'h55);
            chk("t4 denied", d_ready, 0);
        end
        drive(1, 1, 0, 32'h44, 0, 1, 1, 32'h90, 32'h55);
        chk("t4 in stall", c_stall, 1);
        idle();
        chk("t4 stall cleared", c_stall, 0);
        chk("t4 no rsp", r_valid, 0);
        chk("t4 rdata zero", r_rdata, 0);
        chk("t4 mem untouched", mem0[8'h90], 0);

        // Two denials, drop, then a fresh run of four denials
        drive(0, 1, 0, 32'h44, 0, 1, 0, 32'h40, 0);
        drive(0, 1, 0, 32'h44, 0, 1, 0, 32'h40, 0);
        drive(0, 1, 0, 32'h44, 0, 0, 0, 32'h40, 0);
        chk("t5 drop no stall", c_stall, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 0, 32'h44, 0, 1, 0, 32'h40, 0);
            chk($sformatf("t5 stall c%0d", i), c_stall, i == 5);
            chk($sformatf("t5 ready c%0d", i), d_ready, i == 5);
        end
        idle();
        idle();

        // STARVE_LIMIT=1 instance: stall alternates, response every other cycle
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 0, 32'h44, 0, 1, 0, 32'h40, 0);
            chk($sformatf("t6 stall c%0d", i), c_stall1, (i % 2) == 0);
            chk($sformatf("t6 rsp c%0d", i), r_valid1, (i > 1) && (i % 2 == 1));
        end
        idle();
        idle();

        // Randomized traffic; DMA fields held while waiting for a grant
        pend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (pend && $urandom_range(0, 7) != 0) begin
                nv = 1'b1; nw = dwe; na = da; nd = dd;
            end else begin
                nv = ($urandom_range(0, 2) != 0);
                nw = $urandom_range(0, 1) == 1;
                na = 32'h40 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 1)) * 32'h40;
                nd = $urandom;
            end
            nr  = $urandom_range(0, 3) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0;
            ncw = $urandom_range(0, 3) == 0;
            drive($urandom_range(0, 99) == 0, nr, ncw,
                  32'h40 + 32'($urandom_range(0, 7)) * 4, $urandom,
                  nv, nw, na, nd);
            pend = dv & ~d_ready;
        end
        idle();
        idle();
        for (int a = 32'h40; a < 32'h60; a += 4)
            chk($sformatf("final mem %0h", a), mem0[a], refmem[a]);
        for (int a = 32'h80; a < 32'h90; a += 4)
            chk($sformatf("final mem %0h", a), mem0[a], refmem[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
